muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have ports (one per line: name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand; captured on accept.
- b  in  32  rs2 operand; captured on accept.
- flush  in  1  abort in-flight operation.
- ready  out  1  can accept a new request this cycle.
- busy  out  1  operation in flight; the pipeline stalls on busy.
- done  out  1  result valid; one-cycle pulse.
- result  out  32  result; held stable until the next accept.
REQ-002 SHALL contain no parameters; all widths are fixed at 32.

Function
REQ-010 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-011 SHALL set ready=1 in IDLE or DONE and ready=0 otherwise.
REQ-012 SHALL set busy=1 in CALC or FIX and busy=0 otherwise.
REQ-013 SHALL set done=1 only in DONE.
REQ-014 Accept = start & ready & ~flush; on accept SHALL latch op, a and b, and record operand signs per op signedness.
REQ-015 Iterative path SHALL be: accept, then CALC for exactly 32 cycles (5-bit counter, 0..31), then FIX for 1 cycle, then DONE.
- done is asserted 34 cycles after the accept edge.
REQ-016 Division in CALC SHALL be radix-2 restoring on magnitudes, 1 quotient bit per cycle, with a 33-bit partial remainder.
REQ-017 FIX SHALL negate the quotient if the signs differ (DIV) and negate the remainder if the dividend is negative (REM).
REQ-018 Divide by zero SHALL transition accept to DONE directly (done 1 cycle after accept), with result as follows:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: a.
REQ-019 Signed overflow (a=0x80000000, b=0xFFFFFFFF) SHALL transition accept to DONE directly, with result as follows:
- DIV: 0x80000000.
- REM: 0.
REQ-020 MUL SHALL return product[31:0].
- MULH/MULHSU/MULHU SHALL return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
REQ-021 result SHALL update only on entry to DONE and SHALL retain its value through IDLE.
REQ-022 DONE SHALL last exactly 1 cycle, then go to IDLE unless a new accept occurs in DONE (back-to-back accept goes straight to CALC, or to DONE for special cases).
REQ-023 start while ready=0 SHALL be ignored and not queued.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state.
- done SHALL not be asserted for the aborted operation.
- result SHALL be unchanged.
REQ-025 flush and start in the same cycle SHALL give no accept; flush wins.
REQ-026 op and operands SHALL be ignored after accept; input changes during busy SHALL not affect result.

Reset
REQ-030 rst=1 at a clock edge SHALL set:
- state=IDLE.
- counter=0.
- result=0.
- done=0, busy=0; ready=1 after that edge.
REQ-031 rst SHALL take priority over flush and start.
REQ-032 rst mid-operation SHALL abort with no done pulse.

Configuration
REQ-040 Macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
- Defined: all multiply ops SHALL use a single-cycle 33x33 signed product and go accept to DONE (done 1 cycle after accept).
- Undefined: multiply SHALL use 32 cycles of shift-add in CALC plus a FIX sign correction, following REQ-015 latency (34 cycles).
REQ-041 Division behaviour SHALL be identical with or without MULDIV_FAST_MUL_EN.

Verification
REQ-050 DIV a=-7 (0xFFFFFFF9), b=2 -> done 34 cycles after accept, result=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-051 DIVU a=100, b=0 -> done 1 cycle after accept, result=0xFFFFFFFF; REMU a=100, b=0 -> result=100.
REQ-052 DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 in 1 cycle; REM same operands -> 0.
REQ-053 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- Latency 1 cycle with MULDIV_FAST_MUL_EN defined, 34 cycles without.
REQ-054 Accept DIVU 10/3, assert flush at CALC cycle 10 -> IDLE next cycle, no done, result keeps its prior value; start held during busy is not accepted.
REQ-055 Back-to-back: start held high through DONE of DIVU 10/3 (result=3) -> second op accepted in DONE, busy next cycle, no idle bubble.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   start, op, a, b - request (op = RV32M funct3), captured when accepted
//   flush           - aborts the in-flight operation (forces IDLE)
//   ready           - a request may be accepted this cycle (IDLE or DONE)
//   busy            - operation in flight (CALC or FIX)
//   done            - one-cycle pulse, result valid
//   result          - last completed result, held until the next one lands
//
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier
// (multiplies go accept -> DONE). Without it, multiplies take the same
// 32-step CALC + FIX path as division.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;        // remainder (div) / product high half (mul)
  logic [31:0] lo_q, lo_d;        // dividend->quotient (div) / multiplier->product low (mul)
  logic [31:0] mcand_q, mcand_d;  // |divisor| or |multiplicand|
  logic        neg_q, neg_d;      // operand signs differ: negate quotient/product
  logic        neg_rem_q, neg_rem_d; // dividend negative: negate remainder
  logic [31:0] result_q, result_d;

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

  // ---------------- request decode ----------------
  logic        accept;
  logic        sgn_a, sgn_b, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;

  assign accept = start & ready & ~flush;

  // Div ops: op[0]=0 is signed. Mul ops: rs1 signed except MULHU,
  // rs2 signed only for MUL/MULH (op[1]=0).
  assign sgn_a = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign sgn_b = op[2] ? ~op[0] : ~op[1];
  assign neg_a = sgn_a & a[31];
  assign neg_b = sgn_b & b[31];
  assign mag_a = neg_a ? (~a + 32'd1) : a;
  assign mag_b = neg_b ? (~b + 32'd1) : b;

  assign div_zero = op[2] & (b == 32'd0);
  assign div_ovf  = op[2] & ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  // op[1] selects REM* over DIV*
  assign special_res = div_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                                : (op[1] ? 32'd0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
  // 33x33 signed product; only the low 64 bits are ever needed, so the
  // operands are extended to 64 and the wrapped product is exact there.
  logic signed [63:0] fa, fb, fprod;
  logic        [31:0] fast_res;
  assign fa       = {{31{sgn_a & a[31]}}, sgn_a & a[31], a};
  assign fb       = {{31{sgn_b & b[31]}}, sgn_b & b[31], b};
  assign fprod    = fa * fb;
  assign fast_res = (op == OP_MUL) ? fprod[31:0] : fprod[63:32];
`endif

  // ---------------- iteration step ----------------
  // Restoring divide: 33-bit partial remainder. When the subtract succeeds
  // the true difference is below the divisor, so a 32-bit wrap is exact.
  logic [32:0] shifted;
  logic        q_bit;
  logic [31:0] rem_next;
  assign shifted  = {hi_q, lo_q[31]};
  assign q_bit    = (shifted >= {1'b0, mcand_q});
  assign rem_next = q_bit ? (shifted[31:0] - mcand_q) : shifted[31:0];

  // Shift-add multiply on magnitudes, product shifts right through hi:lo.
  logic [32:0] sum;
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);

  // ---------------- sign fix-up ----------------
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_res;
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
  assign quo_fix  = neg_q ? (~lo_q + 32'd1) : lo_q;
  assign rem_fix  = neg_rem_q ? (~hi_q + 32'd1) : hi_q;

  always_comb begin
    fix_res = prod_fix[63:32];
    case (op_q)
      OP_MUL:                    fix_res = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[63:32];
      OP_DIV, OP_DIVU:           fix_res = quo_fix;
      OP_REM, OP_REMU:           fix_res = rem_fix;
      default:                   fix_res = prod_fix[63:32];
    endcase
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          hi_d = rem_next;
          lo_d = {lo_q[30:0], q_bit};
        end else begin
          hi_d = sum[32:1];
          lo_d = {sum[0], lo_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Accept is only possible in IDLE/DONE, so it overrides DONE -> IDLE.
    if (accept) begin
      op_d      = op;
      hi_d      = 32'd0;
      lo_d      = mag_a;
      mcand_d   = mag_b;
      neg_d     = neg_a ^ neg_b;
      neg_rem_d = neg_a;
      cnt_d     = 5'd0;
      if (div_zero || div_ovf) begin
        state_d  = DONE;
        result_d = special_res;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!op[2]) begin
        state_d  = DONE;
        result_d = fast_res;
      end
`endif
      else begin
        state_d = CALC;
      end
    end

    // Flush beats everything; an aborted FIX must not land its result.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mcand_q   <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule
